// File: rtl/mult_sched.sv
`default_nettype none
// ============================================================================
// Module   : mult_sched
// Desc     : Round-robin scheduler sharing one multiplier engine between two
//            requesters. Define MULT_SCHED_TIMEOUT_EN to add a WAIT watchdog.
// Revision : 1.0 - initial release
// ============================================================================
module mult_sched (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  req,
  input  logic [23:0] op_a0,
  input  logic [23:0] op_b0,
  input  logic [23:0] op_a1,
  input  logic [23:0] op_b1,
  output logic [1:0]  ack,
  output logic [31:0] res,
  output logic        res_valid,
  output logic [5:0]  res_ones,
  output logic        res_id,
  output logic        eng_start,
  output logic [23:0] eng_a,
  output logic [23:0] eng_b,
  input  logic        eng_done,
  input  logic [48:0] eng_result,
  input  logic [5:0]  eng_ones,
  output logic        busy,
  output logic [15:0] op_count,
  output logic        tmo
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } state_t;

  state_t r_state;
  logic   r_ptr;
  logic   r_id;
  logic   w_grant;

  // The pointer only breaks ties; a lone request always wins.
  assign w_grant = (req == 2'b11) ? r_ptr : req[1];

`ifdef MULT_SCHED_TIMEOUT_EN
  logic [7:0] r_wdog;
  logic [7:0] w_wdog_next;
  assign w_wdog_next = r_wdog + 8'd1;
`else
  assign tmo = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_ptr     <= 1'b0;
      r_id      <= 1'b0;
      ack       <= 2'b00;
      eng_start <= 1'b0;
      eng_a     <= 24'd0;
      eng_b     <= 24'd0;
      res       <= 32'd0;
      res_valid <= 1'b1;
      res_ones  <= 6'd0;
      res_id    <= 1'b0;
      busy      <= 1'b0;
      op_count  <= 16'd0;
`ifdef MULT_SCHED_TIMEOUT_EN
      tmo       <= 1'b0;
      r_wdog    <= 8'd0;
`endif
    end else begin
      ack       <= 2'b00;
      eng_start <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (req != 2'b00) begin
            r_id      <= w_grant;
            eng_a     <= w_grant ? op_a1 : op_a0;
            eng_b     <= w_grant ? op_b1 : op_b0;
            eng_start <= 1'b1;
            busy      <= 1'b1;
            r_state   <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          r_state <= S_WAIT;
`ifdef MULT_SCHED_TIMEOUT_EN
          r_wdog  <= 8'd0;
`endif
        end
        S_WAIT: begin
          if (eng_done) begin
            res       <= eng_result[31:0];
            res_valid <= (eng_result[48:32] == 17'd0);
            res_ones  <= eng_ones;
            res_id    <= r_id;
            ack       <= r_id ? 2'b10 : 2'b01;
            r_state   <= S_RESP;
`ifdef MULT_SCHED_TIMEOUT_EN
            tmo       <= 1'b0;
`endif
          end
`ifdef MULT_SCHED_TIMEOUT_EN
          // Give up on the 255th WAIT cycle and report an invalid zero result.
          else if (w_wdog_next == 8'd255) begin
            res       <= 32'd0;
            res_valid <= 1'b0;
            res_ones  <= 6'd0;
            res_id    <= r_id;
            tmo       <= 1'b1;
            ack       <= r_id ? 2'b10 : 2'b01;
            r_state   <= S_RESP;
          end else begin
            r_wdog    <= w_wdog_next;
          end
`endif
        end
        S_RESP: begin
          op_count <= op_count + 16'd1;
          r_ptr    <= ~r_id;
          busy     <= 1'b0;
          r_state  <= S_IDLE;
        end
        default: begin
          busy    <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mult_sched.sv
`default_nettype none
// ============================================================================
// Module   : tb_mult_sched
// Desc     : Self-checking bench for mult_sched with a behavioural engine and
//            a transaction-level arbitration/result model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mult_sched;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  req;
  logic [23:0] opa [2];
  logic [23:0] opb [2];
  logic [1:0]  ack;
  logic [31:0] res;
  logic        res_valid;
  logic [5:0]  res_ones;
  logic        res_id;
  logic        eng_start;
  logic [23:0] eng_a;
  logic [23:0] eng_b;
  logic        eng_done;
  logic [48:0] eng_result;
  logic [5:0]  eng_ones;
  logic        busy;
  logic [15:0] op_count;
  logic        tmo;

  int          checks = 0;
  int          errors = 0;

  bit          eng_auto;
  int          eng_delay;
  int          eng_cnt;
  logic [48:0] eng_pend;

  mult_sched dut (
    .clk        (clk),
    .reset      (reset),
    .req        (req),
    .op_a0      (opa[0]),
    .op_b0      (opb[0]),
    .op_a1      (opa[1]),
    .op_b1      (opb[1]),
    .ack        (ack),
    .res        (res),
    .res_valid  (res_valid),
    .res_ones   (res_ones),
    .res_id     (res_id),
    .eng_start  (eng_start),
    .eng_a      (eng_a),
    .eng_b      (eng_b),
    .eng_done   (eng_done),
    .eng_result (eng_result),
    .eng_ones   (eng_ones),
    .busy       (busy),
    .op_count   (op_count),
    .tmo        (tmo)
  );

  always #5 clk = ~clk;

  function automatic logic [48:0] mul(input logic [23:0] a, input logic [23:0] b);
    return {25'd0, a} * {25'd0, b};
  endfunction

  // Advance one clock; sample point is 1 ns after the rising edge.
  // The engine model answers eng_delay cycles after it sees eng_start.
  task automatic step();
    @(posedge clk);
    #1;
    if (eng_done) eng_done = 1'b0;
    if (eng_cnt > 0) begin
      eng_cnt--;
      if (eng_cnt == 0) begin
        eng_done   = 1'b1;
        eng_result = eng_pend;
        eng_ones   = 6'($countones(eng_pend[31:0]));
      end
    end
    if (eng_auto && eng_start) begin
      eng_pend = mul(eng_a, eng_b);
      eng_cnt  = eng_delay;
    end
  endtask

  task automatic do_reset();
    reset    = 1'b1;
    req      = 2'b00;
    eng_done = 1'b0;
    eng_cnt  = 0;
    step();
    step();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if ({ack, eng_start, eng_a, eng_b, res, res_valid, res_ones, res_id, busy, op_count, tmo} !==
        {2'b00, 1'b0, 24'd0, 24'd0, 32'd0, 1'b1, 6'd0, 1'b0, 1'b0, 16'd0, 1'b0}) begin
      errors++;
      $display("FAIL reset_state: ack=%b start=%b a=%h b=%h res=%h valid=%b ones=%0d id=%b busy=%b cnt=%h tmo=%b",
               ack, eng_start, eng_a, eng_b, res, res_valid, res_ones, res_id, busy, op_count, tmo);
    end
  endtask

  task automatic test_basic();
    do_reset();
    eng_auto = 1'b1; eng_delay = 1;
    opa[0] = 24'h000003; opb[0] = 24'h000005; req = 2'b01;
    step();
    checks++;
    if (eng_start !== 1'b1 || busy !== 1'b1 || eng_a !== 24'h3 || eng_b !== 24'h5) begin
      errors++;
      $display("FAIL basic_issue: start=%b busy=%b a=%h b=%h expected 1 1 000003 000005", eng_start, busy, eng_a, eng_b);
    end
    step();
    checks++;
    if (eng_start !== 1'b0 || ack !== 2'b00) begin
      errors++;
      $display("FAIL basic_wait: start=%b ack=%b expected 0 00", eng_start, ack);
    end
    step();
    checks++;
    if (ack !== 2'b01 || res !== 32'h0000000F || res_valid !== 1'b1 || res_ones !== 6'd4 ||
        res_id !== 1'b0 || tmo !== 1'b0 || eng_a !== 24'h3) begin
      errors++;
      $display("FAIL basic_resp: ack=%b res=%h valid=%b ones=%0d id=%b tmo=%b expected 01 0000000f 1 4 0 0",
               ack, res, res_valid, res_ones, res_id, tmo);
    end
    req = 2'b00;
    step();
    checks++;
    if (ack !== 2'b00 || op_count !== 16'd1 || busy !== 1'b0 || res !== 32'h0000000F) begin
      errors++;
      $display("FAIL basic_done: ack=%b op_count=%0d busy=%b res=%h expected 00 1 0 0000000f", ack, op_count, busy, res);
    end
  endtask

  task automatic test_back_to_back();
    logic [1:0]  order [2];
    logic [31:0] resv  [2];
    int          at    [2];
    int          seen;
    do_reset();
    eng_auto = 1'b1; eng_delay = 1;
    opa[0] = 24'd7;  opb[0] = 24'd9;
    opa[1] = 24'd11; opb[1] = 24'd13;
    req = 2'b11; seen = 0;
    for (int c = 0; c < 30 && seen < 2; c++) begin
      step();
      if (ack != 2'b00) begin
        order[seen] = ack; resv[seen] = res; at[seen] = c;
        req = req & ~ack;
        seen++;
      end
    end
    checks++;
    if (seen != 2) begin
      errors++;
      $display("FAIL b2b_count: acks=%0d expected 2", seen);
    end else begin
      checks++;
      if (order[0] !== 2'b01 || order[1] !== 2'b10) begin
        errors++;
        $display("FAIL b2b_order: got %b,%b expected 01,10", order[0], order[1]);
      end
      checks++;
      if (resv[0] !== 32'd63 || resv[1] !== 32'd143) begin
        errors++;
        $display("FAIL b2b_results: got %0d,%0d expected 63,143", resv[0], resv[1]);
      end
      checks++;
      if (at[1] - at[0] != 4) begin
        errors++;
        $display("FAIL b2b_gap: got %0d cycles expected 4", at[1] - at[0]);
      end
    end
  endtask

  task automatic test_drop();
    bit got;
    do_reset();
    eng_auto = 1'b1; eng_delay = 3;
    opa[1] = 24'd100; opb[1] = 24'd200; req = 2'b10;
    step();
    req = 2'b00;
    got = 1'b0;
    for (int c = 0; c < 10 && !got; c++) begin
      step();
      if (ack != 2'b00) got = 1'b1;
    end
    checks++;
    if (!got || ack !== 2'b10 || res !== 32'd20000 || res_id !== 1'b1) begin
      errors++;
      $display("FAIL drop_req: got=%b ack=%b res=%0d id=%b expected 1 10 20000 1", got, ack, res, res_id);
    end
  endtask

  task automatic test_spurious();
    do_reset();
    eng_auto = 1'b0;
    eng_done = 1'b1; eng_result = 49'h0_1234_5678_9ABC; eng_ones = 6'd33;
    step();
    checks++;
    if (busy !== 1'b0 || ack !== 2'b00 || res !== 32'd0 || res_ones !== 6'd0) begin
      errors++;
      $display("FAIL spurious_idle: busy=%b ack=%b res=%h ones=%0d expected 0 00 0 0", busy, ack, res, res_ones);
    end
    opa[0] = 24'd2; opb[0] = 24'd3; req = 2'b01;
    step();
    eng_done = 1'b1;
    step();
    req = 2'b00;
    step();
    checks++;
    if (busy !== 1'b1 || ack !== 2'b00 || res !== 32'd0) begin
      errors++;
      $display("FAIL spurious_issue: busy=%b ack=%b res=%h expected 1 00 0", busy, ack, res);
    end
    eng_done = 1'b1; eng_result = 49'd6; eng_ones = 6'd2;
    step();
    checks++;
    if (ack !== 2'b01 || res !== 32'd6 || res_ones !== 6'd2) begin
      errors++;
      $display("FAIL spurious_wait: ack=%b res=%h ones=%0d expected 01 6 2", ack, res, res_ones);
    end
    step();
  endtask

  task automatic test_overflow();
    logic [48:0] p;
    bit          got;
    do_reset();
    eng_auto = 1'b1; eng_delay = 2;
    opa[0] = 24'hFFFFFF; opb[0] = 24'hFFFFFF; req = 2'b01;
    p = mul(24'hFFFFFF, 24'hFFFFFF);
    got = 1'b0;
    for (int c = 0; c < 10 && !got; c++) begin
      step();
      if (ack != 2'b00) got = 1'b1;
    end
    req = 2'b00;
    checks++;
    if (!got || res !== 32'hFE000001 || res_valid !== 1'b0 || res_ones !== 6'($countones(p[31:0]))) begin
      errors++;
      $display("FAIL overflow: got=%b res=%h valid=%b ones=%0d expected fe000001 0 %0d",
               got, res, res_valid, res_ones, $countones(p[31:0]));
    end
    step();
    step();
    checks++;
    if (res !== 32'hFE000001 || res_valid !== 1'b0) begin
      errors++;
      $display("FAIL overflow_hold: res=%h valid=%b expected fe000001 0", res, res_valid);
    end
  endtask

  task automatic test_reset_mid();
    bit any_ack;
    do_reset();
    eng_auto = 1'b0;
    opa[0] = 24'd5; opb[0] = 24'd5; req = 2'b01;
    step();
    step();
    step();
    reset = 1'b1;
    step();
    reset = 1'b0; req = 2'b00;
    eng_done = 1'b1; eng_result = 49'd25; eng_ones = 6'd3;
    any_ack = 1'b0;
    for (int c = 0; c < 5; c++) begin
      step();
      if (ack != 2'b00) any_ack = 1'b1;
    end
    checks++;
    if (any_ack || busy !== 1'b0 || op_count !== 16'd0 || res !== 32'd0) begin
      errors++;
      $display("FAIL reset_mid: ack_seen=%b busy=%b op_count=%0d res=%h expected 0 0 0 0", any_ack, busy, op_count, res);
    end
  endtask

  task automatic test_random();
    logic [1:0]  req_prev;
    logic        exp_ptr;
    logic        cur_id;
    logic [23:0] ga, gb;
    logic [48:0] p;
    logic [1:0]  exp_ack;
    int          exp_count;
    int          acks;
    bit          cnt_pend;
    do_reset();
    eng_auto = 1'b1;
    exp_ptr = 1'b0; cur_id = 1'b0; ga = 24'd0; gb = 24'd0;
    exp_count = 0; acks = 0; cnt_pend = 1'b0;
    for (int cyc = 0; cyc < 3000 && acks < 60; cyc++) begin
      eng_delay = $urandom_range(1, 4);
      req_prev = req;
      step();
      if (cnt_pend) begin
        cnt_pend = 1'b0;
        checks++;
        if (op_count !== 16'(exp_count)) begin
          errors++;
          $display("FAIL rand_count: op_count=%0d expected %0d", op_count, exp_count);
        end
      end
      if (eng_start) begin
        cur_id = (req_prev == 2'b11) ? exp_ptr : req_prev[1];
        ga = opa[cur_id]; gb = opb[cur_id];
        checks++;
        if (req_prev == 2'b00 || eng_a !== ga || eng_b !== gb) begin
          errors++;
          $display("FAIL rand_grant: req=%b a=%h b=%h expected requester %0d a=%h b=%h",
                   req_prev, eng_a, eng_b, cur_id, ga, gb);
        end
      end
      if (ack != 2'b00) begin
        p = mul(ga, gb);
        exp_ack = cur_id ? 2'b10 : 2'b01;
        checks++;
        if (ack !== exp_ack || res !== p[31:0] || res_valid !== (p[48:32] == 17'd0) ||
            res_ones !== 6'($countones(p[31:0])) || res_id !== cur_id || tmo !== 1'b0) begin
          errors++;
          $display("FAIL rand_result: ack=%b res=%h valid=%b ones=%0d id=%b tmo=%b expected %b %h %b %0d %b 0",
                   ack, res, res_valid, res_ones, res_id, tmo, exp_ack, p[31:0], (p[48:32] == 17'd0),
                   $countones(p[31:0]), cur_id);
        end
        exp_ptr = ~cur_id;
        exp_count++;
        cnt_pend = 1'b1;
        acks++;
        req[cur_id] = 1'b0;
      end
      for (int i = 0; i < 2; i++) begin
        if (!req[i] && $urandom_range(0, 2) == 0) begin
          opa[i] = $urandom_range(0, 1) ? 24'($urandom) : 24'($urandom_range(0, 4095));
          opb[i] = $urandom_range(0, 1) ? 24'($urandom) : 24'($urandom_range(0, 4095));
          req[i] = 1'b1;
        end
      end
    end
    checks++;
    if (acks < 60) begin
      errors++;
      $display("FAIL rand_progress: acks=%0d expected 60", acks);
    end
    req = 2'b00;
    step();
    step();
  endtask

`ifdef MULT_SCHED_TIMEOUT_EN
  task automatic test_timeout();
    int n;
    bit got;
    do_reset();
    eng_auto = 1'b0;
    opa[0] = 24'd9; opb[0] = 24'd9; req = 2'b01;
    n = 0; got = 1'b0;
    while (!got && n < 400) begin
      step();
      n++;
      if (ack != 2'b00) got = 1'b1;
    end
    req = 2'b00;
    checks++;
    if (!got || ack !== 2'b01 || n < 256 || n > 258) begin
      errors++;
      $display("FAIL timeout_ack: got=%b ack=%b after %0d cycles expected 01 after about 257", got, ack, n);
    end
    checks++;
    if (tmo !== 1'b1 || res_valid !== 1'b0 || res !== 32'd0 || res_ones !== 6'd0) begin
      errors++;
      $display("FAIL timeout_result: tmo=%b valid=%b res=%h ones=%0d expected 1 0 0 0", tmo, res_valid, res, res_ones);
    end
    step();
    checks++;
    if (op_count !== 16'd1 || tmo !== 1'b1) begin
      errors++;
      $display("FAIL timeout_count: op_count=%0d tmo=%b expected 1 1", op_count, tmo);
    end
  endtask
`endif

  initial begin
    reset = 1'b1; req = 2'b00;
    opa[0] = 24'd0; opb[0] = 24'd0; opa[1] = 24'd0; opb[1] = 24'd0;
    eng_done = 1'b0; eng_result = 49'd0; eng_ones = 6'd0;
    eng_auto = 1'b0; eng_delay = 1; eng_cnt = 0; eng_pend = 49'd0;
    test_reset();
    test_basic();
    test_back_to_back();
    test_drop();
    test_spurious();
    test_overflow();
    test_reset_mid();
    test_random();
`ifdef MULT_SCHED_TIMEOUT_EN
    test_timeout();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/mult_sched.md
MULT_SCHED -- requirements
Module: mult_sched

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset: clk is the only clock, and reset is sampled on the rising edge of clk.
REQ-002 clk  in  1  rising-edge system clock.
REQ-003 reset  in  1  synchronous, active-high reset.
REQ-004 req  in  2  request per requester; bit i belongs to requester i; held high until ack[i].
REQ-005 op_a0, op_b0  in  24 each  operands of requester 0.
REQ-006 op_a1, op_b1  in  24 each  operands of requester 1.
REQ-007 ack  out  2  one-cycle completion pulse per requester.
REQ-008 res  out  32  result[31:0] of the last completed operation.
REQ-009 res_valid  out  1  1 = last product fits in 32 bits (result[48:32]==0).
REQ-010 res_ones  out  6  ones count of res, as reported by the engine.
REQ-011 res_id  out  1  requester that owns res.
REQ-012 eng_start  out  1  one-cycle start pulse to the shared multiplier engine.
REQ-013 eng_a, eng_b  out  24 each  operands driven to the engine.
REQ-014 eng_done  in  1  engine completion pulse.
REQ-015 eng_result  in  49  engine product.
REQ-016 eng_ones  in  6  engine popcount of eng_result[31:0].
REQ-017 busy  out  1  high whenever state != IDLE.
REQ-018 op_count  out  16  number of completed operations.
REQ-019 tmo  out  1  high while the last completed operation timed out.

Function
REQ-020 The FSM SHALL have four states: IDLE, ISSUE, WAIT and RESP.
REQ-021 In IDLE with any req bit high, the block SHALL select a requester, latch its operands onto eng_a/eng_b, latch its index as the current id, and go to ISSUE.
REQ-022 Selection SHALL be round-robin: when both requests are high, the requester that matches the priority pointer wins; reset sets the pointer to 0.
REQ-023 When a single request is high, that requester SHALL win regardless of the pointer.
REQ-024 In ISSUE, eng_start SHALL be 1 for exactly one cycle, after which the FSM goes to WAIT.
REQ-025 eng_a and eng_b SHALL stay stable from ISSUE through RESP.
REQ-026 An eng_done that arrives outside WAIT SHALL be ignored.
REQ-027 In WAIT, when eng_done is 1, the block SHALL capture res=eng_result[31:0], res_valid=(eng_result[48:32]==0), res_ones=eng_ones, res_id=current id and tmo=0, then go to RESP.
REQ-028 In RESP, ack[id] SHALL be 1 for one cycle, op_count SHALL increment (0xFFFF wraps to 0x0000), the pointer SHALL move to the other requester, and the FSM SHALL return to IDLE.
REQ-029 Minimum latency SHALL be: request sampled in IDLE at edge N, eng_start high during cycle N+1, eng_done sampled at N+2, ack high during cycle N+3.
REQ-030 If a requester drops req after it has been granted, the operation SHALL still complete and ack SHALL still pulse.
REQ-031 The res, res_valid, res_ones, res_id and tmo outputs SHALL hold their values until the next capture.
REQ-032 A requester that keeps req high through RESP SHALL be re-arbitrated in the next IDLE cycle, and the other requester SHALL win if it is also requesting.

Reset
REQ-033 Reset SHALL put the FSM in IDLE, set the pointer to 0, and clear ack, eng_start, eng_a, eng_b, res, res_ones, res_id, tmo, busy and op_count to 0; res_valid SHALL reset to 1.
REQ-034 Reset asserted mid-operation SHALL abort the operation without any ack, and a later eng_done SHALL be ignored.

Configuration
REQ-035 With MULT_SCHED_TIMEOUT_EN defined, an 8-bit watchdog SHALL count cycles in WAIT; on reaching 255 without eng_done, the block SHALL capture res=0, res_valid=0, res_ones=0, tmo=1 and go to RESP, where ack is issued and op_count increments as normal.
REQ-036 Without MULT_SCHED_TIMEOUT_EN, WAIT SHALL last until eng_done, and tmo SHALL be tied to 0.

Verification
REQ-037 req=01, op_a0=0x000003, op_b0=0x000005, engine returns 15 / ones=4 one cycle after start -> ack=01 during cycle N+3, res=0x0000000F, res_valid=1, res_ones=4, op_count=1.
REQ-038 req=11 from reset -> requester 0 served first, then requester 1, and ack order is 01 then 10.
REQ-039 Operands 0xFFFFFF x 0xFFFFFF, engine returns 0xFFFFFE000001 -> res=0xFE000001, res_valid=0.
REQ-040 op_count preloaded to 0xFFFF via 65535 operations, one more operation completed -> op_count=0x0000.
REQ-041 Reset asserted during WAIT, then eng_done -> no ack, busy=0, FSM in IDLE.
REQ-042 With MULT_SCHED_TIMEOUT_EN, eng_done never asserted -> ack after 255 WAIT cycles with tmo=1 and res_valid=0.
